// File: rtl/fpnew_pkg.sv
// Shared arbitration types and the cyclic round-robin search helper used by
// fpnew_rr_pick and fpnew_slice_arbiter.
package fpnew_pkg;

   localparam int unsigned ArbIdMaxW = 8;
   localparam int unsigned ArbMaxReq = 2 ** ArbIdMaxW;

   typedef logic [ArbIdMaxW-1:0] arb_id_t;

   typedef enum logic {
      LOCK_OPEN,
      LOCK_HELD
   } arb_lock_e;

   // Lowest cyclic offset from ptr wins; returns ptr when nothing is valid.
   function automatic arb_id_t rr_pick(input logic [ArbMaxReq-1:0] valid,
                                       input arb_id_t ptr,
                                       input int unsigned num);
      int unsigned idx;
      rr_pick = ptr;
      for (int unsigned i = 0; i < num; i++) begin
         idx = int'(ptr) + (num - 1 - i);
         if (idx >= num) idx = idx - num;
         if (valid[idx]) rr_pick = arb_id_t'(idx);
      end
   endfunction

endpackage

// File: rtl/fpnew_rr_pick.sv
// Combinational cyclic priority encoder: first valid index at or after ptr_i.
module fpnew_rr_pick
   import fpnew_pkg::*;
#(
   parameter int unsigned NumReq  = 2,
   parameter int unsigned IdWidth = 1
) (
   input  logic [NumReq-1:0]  valid_i,
   input  logic [IdWidth-1:0] ptr_i,
   output logic [IdWidth-1:0] idx_o,
   output logic               found_o
);

   logic [ArbMaxReq-1:0] valid_ext;

   always_comb begin
      valid_ext               = '0;
      valid_ext[NumReq-1:0]   = valid_i;
      idx_o   = IdWidth'(rr_pick(valid_ext, arb_id_t'(ptr_i), NumReq));
      found_o = |valid_i;
   end

endmodule

// File: rtl/fpnew_slice_arbiter.sv
// Round-robin sharing of one FPU format slice between NumReq requesters with
// grant lock, credit bound, flush and ID-routed responses. Optional perf
// counters are enabled by defining FPNEW_SLICE_ARB_PERF_EN.
module fpnew_slice_arbiter
   import fpnew_pkg::*;
#(
   parameter int unsigned NumReq   = 2,
   parameter int unsigned ReqWidth = 72,
   parameter int unsigned RspWidth = 38,
   parameter int unsigned MaxOutst = 4,
   localparam int unsigned IdWidth  = (NumReq > 2) ? $clog2(NumReq) : 1,
   localparam int unsigned CntWidth = $clog2(MaxOutst + 1)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic [NumReq-1:0]          req_valid_i,
   output logic [NumReq-1:0]          req_ready_o,
   input  logic [NumReq*ReqWidth-1:0] req_data_i,
   output logic                       slc_valid_o,
   input  logic                       slc_ready_i,
   output logic [ReqWidth-1:0]        slc_data_o,
   output logic [IdWidth-1:0]         slc_tag_o,
   input  logic                       slc_rsp_valid_i,
   output logic                       slc_rsp_ready_o,
   input  logic [RspWidth-1:0]        slc_rsp_data_i,
   input  logic [IdWidth-1:0]         slc_rsp_tag_i,
   output logic [NumReq-1:0]          rsp_valid_o,
   input  logic [NumReq-1:0]          rsp_ready_i,
   output logic [RspWidth-1:0]        rsp_data_o,
   output logic                       busy_o
`ifdef FPNEW_SLICE_ARB_PERF_EN
   ,
   output logic [NumReq*32-1:0]       perf_grant_o,
   output logic [31:0]                perf_stall_o
`endif
);

   arb_lock_e           lock_q, lock_d;
   logic [IdWidth-1:0]  locked_id_q, locked_id_d;
   logic [IdWidth-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CntWidth-1:0] outst_q, outst_d;
   logic [IdWidth-1:0]  pick_idx, winner;
   logic                pick_found, credit_ok, accept, rsp_hs;

   fpnew_rr_pick #(
      .NumReq  (NumReq),
      .IdWidth (IdWidth)
   ) i_rr_pick (
      .valid_i (req_valid_i),
      .ptr_i   (rr_ptr_q),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   always_comb begin
      winner      = (lock_q == LOCK_HELD) ? locked_id_q : pick_idx;
      credit_ok   = outst_q < CntWidth'(MaxOutst);
      slc_valid_o = rst_ni & pick_found & credit_ok & ~flush_i;
      accept      = slc_valid_o & slc_ready_i;
      slc_data_o  = req_data_i[int'(winner)*ReqWidth +: ReqWidth];
      slc_tag_o   = winner;
      req_ready_o = '0;
      if (accept) req_ready_o[winner] = 1'b1;

      // Tags with no matching requester are silently drained.
      rsp_valid_o     = '0;
      slc_rsp_ready_o = rst_ni;
      for (int unsigned k = 0; k < NumReq; k++) begin
         if (slc_rsp_tag_i == IdWidth'(k)) begin
            rsp_valid_o[k]  = rst_ni & slc_rsp_valid_i;
            slc_rsp_ready_o = rst_ni & rsp_ready_i[k];
         end
      end
      rsp_data_o = slc_rsp_data_i;
      rsp_hs     = slc_rsp_valid_i & slc_rsp_ready_o;
      busy_o     = (outst_q != '0) | slc_valid_o;

      outst_d = outst_q;
      if (flush_i) outst_d = '0;
      else if (accept && !rsp_hs) outst_d = outst_q + 1'b1;
      else if (!accept && rsp_hs && outst_q != '0) outst_d = outst_q - 1'b1;

      lock_d      = lock_q;
      locked_id_d = locked_id_q;
      if (flush_i || accept) begin
         lock_d = LOCK_OPEN;
      end else if (slc_valid_o) begin
         lock_d      = LOCK_HELD;
         locked_id_d = winner;
      end

      rr_ptr_d = rr_ptr_q;
      if (accept) rr_ptr_d = (winner == IdWidth'(NumReq - 1)) ? '0 : winner + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         lock_q      <= LOCK_OPEN;
         locked_id_q <= '0;
         rr_ptr_q    <= '0;
         outst_q     <= '0;
      end else begin
         lock_q      <= lock_d;
         locked_id_q <= locked_id_d;
         rr_ptr_q    <= rr_ptr_d;
         outst_q     <= outst_d;
      end
   end

`ifdef FPNEW_SLICE_ARB_PERF_EN
   logic [31:0] grant_cnt_q [NumReq];
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned k = 0; k < NumReq; k++) grant_cnt_q[k] <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (accept) grant_cnt_q[winner] <= grant_cnt_q[winner] + 32'd1;
         if (pick_found && !accept) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   always_comb begin
      perf_grant_o = '0;
      for (int unsigned k = 0; k < NumReq; k++) perf_grant_o[k*32 +: 32] = grant_cnt_q[k];
      perf_stall_o = stall_cnt_q;
   end
`endif

endmodule

// File: tb/tb_fpnew_slice_arbiter.sv
// Scoreboard bench for fpnew_slice_arbiter: directed scenarios followed by
// randomized traffic, all checked by a negedge monitor against a reference model.
module tb_fpnew_slice_arbiter;

   localparam int NR = 2;
   localparam int RW = 72;
   localparam int SW = 38;
   localparam int MO = 4;

   logic            clk = 1'b0;
   logic            rst_n, flush;
   logic [NR-1:0]   req_valid, req_ready;
   logic [NR*RW-1:0] req_data;
   logic            slc_valid, slc_ready;
   logic [RW-1:0]   slc_data;
   logic [0:0]      slc_tag, slc_rsp_tag;
   logic            slc_rsp_valid, slc_rsp_ready;
   logic [SW-1:0]   slc_rsp_data, rsp_data;
   logic [NR-1:0]   rsp_valid, rsp_ready;
   logic            busy;
   logic [RW-1:0]   rdata [NR];

   typedef struct { int id; logic [RW-1:0] data; } op_t;

   op_t slice_q [$];
   op_t exp_q [$];
   int  acc_log [$];
   int  n_chk = 0, n_fail = 0;
   int  m_start = 0, m_stalled = -1, m_outst = 0, last_acc = -1;
   bit  auto_rsp = 0, rand_mode = 0;
   int  saved;

   assign req_data = {rdata[1], rdata[0]};

   always #5 clk = ~clk;

   fpnew_slice_arbiter #(.NumReq(NR), .ReqWidth(RW), .RspWidth(SW), .MaxOutst(MO)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
      .slc_valid_o(slc_valid), .slc_ready_i(slc_ready), .slc_data_o(slc_data), .slc_tag_o(slc_tag),
      .slc_rsp_valid_i(slc_rsp_valid), .slc_rsp_ready_o(slc_rsp_ready),
      .slc_rsp_data_i(slc_rsp_data), .slc_rsp_tag_i(slc_rsp_tag),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .busy_o(busy)
   );

   function automatic logic [SW-1:0] rsp_of(input logic [RW-1:0] d);
      return d[SW-1:0] ^ 38'h15a5a5a5a5;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic present_rsp();
      slc_rsp_valid = slice_q.size() != 0;
      if (rand_mode && $urandom_range(0, 1) == 0) slc_rsp_valid = 1'b0;
      if (slice_q.size() != 0) begin
         slc_rsp_tag  = 1'(slice_q[0].id);
         slc_rsp_data = rsp_of(slice_q[0].data);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_mode) begin
         if (last_acc >= 0) req_valid[last_acc] = 1'b0;
         for (int k = 0; k < NR; k++) begin
            if (!req_valid[k] && $urandom_range(0, 2) != 0) begin
               req_valid[k] = 1'b1;
               rdata[k] = {8'($urandom), $urandom, $urandom};
            end
         end
         slc_ready = $urandom_range(0, 3) != 0;
         rsp_ready = 2'($urandom);
      end
      if (auto_rsp) present_rsp();
   endtask

   // Reference model: grant goes to the stalled requester if one is pending,
   // otherwise to the first valid requester cyclically after the last accepted one.
   always @(negedge clk) begin : mon
      int  w, j;
      bit  ev, acc, rh, er;
      logic [NR-1:0] erv;
      op_t o;
      last_acc = -1;
      if (!rst_n) begin
         check("rst_slc_valid", slc_valid, 0);
         check("rst_req_ready", req_ready, 0);
         check("rst_rsp_valid", rsp_valid, 0);
         check("rst_slc_rsp_ready", slc_rsp_ready, 0);
         m_start = 0; m_stalled = -1; m_outst = 0;
         slice_q.delete(); exp_q.delete();
      end else begin
         ev = (|req_valid) && m_outst < MO && !flush;
         w  = m_stalled;
         if (w < 0) begin
            w = 0;
            for (int i = NR - 1; i >= 0; i--) begin
               j = (m_start + i) % NR;
               if (req_valid[j]) w = j;
            end
         end
         check("slc_valid", slc_valid, ev);
         if (ev) begin
            check("slc_tag", slc_tag, w);
            check("slc_data", slc_data, rdata[w]);
         end
         acc = ev && slc_ready;
         check("req_ready", req_ready, acc ? (2'b01 << w) : 2'b00);
         er  = rsp_ready[slc_rsp_tag];
         erv = slc_rsp_valid ? (2'b01 << slc_rsp_tag) : 2'b00;
         check("rsp_valid", rsp_valid, erv);
         check("slc_rsp_ready", slc_rsp_ready, er);
         check("busy", busy, m_outst != 0 || ev);
         rh = slc_rsp_valid && er;
         if (rh) begin
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL rsp_unexpected: actual=response expected=none (t=%0t)", $time);
            end else begin
               o = exp_q.pop_front();
               check("sb_rsp_valid", rsp_valid, 2'b01 << o.id);
               check("sb_rsp_data", rsp_data, rsp_of(o.data));
            end
            if (slice_q.size() != 0) void'(slice_q.pop_front());
         end
         if (flush) begin
            m_outst = 0; m_stalled = -1;
            slice_q.delete(); exp_q.delete();
         end else begin
            if (acc && !rh) m_outst++;
            else if (rh && !acc && m_outst > 0) m_outst--;
            if (acc) begin
               m_stalled = -1;
               m_start = (w + 1) % NR;
            end else if (ev) m_stalled = w;
         end
         if (acc) begin
            acc_log.push_back(w);
            last_acc = w;
            o.id = w; o.data = slc_data; slice_q.push_back(o);
            o.data = rdata[w]; exp_q.push_back(o);
         end
      end
   end

   initial begin
      rst_n = 0; flush = 0; req_valid = '0; slc_ready = 0; rsp_ready = '0;
      slc_rsp_valid = 0; slc_rsp_tag = '0; slc_rsp_data = '0;
      rdata[0] = 72'h11_2233_4455_6677_8899;
      rdata[1] = 72'hAA_BBCC_DDEE_FF00_1122;
      repeat (3) tick();
      rst_n = 1;

      // Alternating grants with both requesters always valid.
      req_valid = 2'b11; slc_ready = 1; rsp_ready = 2'b11; auto_rsp = 1;
      acc_log.delete();
      repeat (6) tick();
      check("rr_count", acc_log.size(), 6);
      for (int i = 0; i < 6 && i < acc_log.size(); i++) check("rr_order", acc_log[i], i % 2);
      req_valid = '0;
      repeat (4) tick();

      // Grant lock: requester 0 stalls, requester 1 joins while pointer favours it.
      acc_log.delete();
      req_valid = 2'b01; slc_ready = 1;
      tick();
      slc_ready = 0;
      tick();
      req_valid = 2'b11;
      #2 check("lock_tag_a", slc_tag, 0);
      tick();
      #2 check("lock_tag_b", slc_tag, 0);
      check("lock_no_ready", req_ready, 0);
      tick();
      slc_ready = 1;
      #2 check("lock_release_ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b10;
      #2 check("after_lock_tag", slc_tag, 1);
      tick();
      req_valid = '0;
      check("lock_seq_len", acc_log.size(), 3);
      if (acc_log.size() == 3) begin
         check("lock_seq0", acc_log[0], 0);
         check("lock_seq1", acc_log[1], 0);
         check("lock_seq2", acc_log[2], 1);
      end
      repeat (4) tick();

      // Credit exhaustion without responses.
      auto_rsp = 0; slc_rsp_valid = 0;
      acc_log.delete();
      req_valid = 2'b10; slc_ready = 1;
      tick();
      req_valid = 2'b11;
      repeat (6) tick();
      check("credit_accepts", acc_log.size(), MO);
      if (acc_log.size() > 0) check("credit_first_id", acc_log[0], 1);
      #2 check("credit_block", slc_valid, 0);
      present_rsp();
      rsp_ready = 2'b10;
      #1 check("credit_rsp_valid", rsp_valid, 2'b10);
      check("credit_no_bypass", slc_valid, 0);
      tick();
      slc_rsp_valid = 0;
      #2 check("credit_freed", slc_valid, 1);
      tick();
      #2 check("credit_reblock", slc_valid, 0);
      check("credit_accepts2", acc_log.size(), MO + 1);

      // Accept and response in the same cycle at two outstanding.
      req_valid = '0; rsp_ready = 2'b11; auto_rsp = 1;
      present_rsp();
      tick();
      tick();
      req_valid = 2'b11;
      tick();
      auto_rsp = 0; slc_rsp_valid = 0;
      acc_log.delete();
      repeat (4) tick();
      check("same_cycle_credit", acc_log.size(), 2);

      // Flush while locked with three outstanding.
      req_valid = '0;
      present_rsp();
      tick();
      slc_rsp_valid = 0;
      saved = m_start;
      req_valid = 2'b01 << (1 - saved); slc_ready = 0;
      tick();
      flush = 1; req_valid = 2'b11; slc_ready = 1;
      #2 check("flush_slc_valid", slc_valid, 0);
      check("flush_req_ready", req_ready, 0);
      acc_log.delete();
      tick();
      flush = 0;
      repeat (6) tick();
      check("flush_credit", acc_log.size(), MO);
      if (acc_log.size() > 0) check("flush_rr_kept", acc_log[0], saved);

      // Reset during a stall.
      req_valid = '0; auto_rsp = 1;
      present_rsp();
      tick();
      tick();
      auto_rsp = 0; slc_rsp_valid = 0;
      req_valid = 2'b10; slc_ready = 0;
      tick();
      rst_n = 0; req_valid = 2'b11; slc_ready = 1;
      #2 check("rst_mid_valid", slc_valid, 0);
      check("rst_mid_ready", req_ready, 0);
      tick();
      rst_n = 1;
      #2 check("post_rst_tag", slc_tag, 0);
      check("post_rst_ready", req_ready, 2'b01);
      tick();

      // Randomized traffic.
      req_valid = '0; rand_mode = 1; auto_rsp = 1;
      repeat (3000) tick();
      rand_mode = 0; req_valid = '0; rsp_ready = 2'b11;
      repeat (20) tick();
      check("drain_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
